// File: rtl/pong_pkg.sv
// Pong-wide constants and the match state encoding.
package pong_pkg;
  localparam int unsigned HOR_PIXELS = vga_pkg::HOR_PIXELS;
  localparam int unsigned VER_PIXELS = vga_pkg::VER_PIXELS;
  localparam int unsigned BALL_SIZE  = 15;
  localparam int unsigned X_PAD_L    = 30;
  localparam int unsigned X_PAD_R    = 979;

  // Fixed encodings so legacy consumers decoding the raw state bits keep working.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SERVE = ST_SERVE,
    PLAY  = ST_PLAY,
    OVER  = ST_OVER
  } game_state_t;
endpackage

// File: rtl/vga_pkg.sv
// Display geometry shared by the video pipeline.
package vga_pkg;
  localparam int unsigned HOR_PIXELS = 1024;
  localparam int unsigned VER_PIXELS = 768;
endpackage

// File: rtl/tick_counter.sv
// Counts enabled tick pulses modulo MAX; done marks the tick that wraps the count.
module tick_counter #(
  parameter int unsigned MAX = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic tick,
  output logic done
);
  localparam int unsigned   CW   = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX - 1);

  logic [CW-1:0] r_count;
  logic          w_step;
  logic          w_hit;

  assign w_step = en & tick;
  assign w_hit  = w_step & (r_count == LAST);
  assign done   = w_hit;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (w_step) begin
      r_count <= w_hit ? '0 : r_count + CW'(1);
    end
  end
endmodule

// File: rtl/game_fsm.sv
// Pong match controller: goal detection, score keeping, serve pause and winner.
module game_fsm
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 5,
  parameter int unsigned PAUSE_TICKS = 60,
  parameter int unsigned GOAL_MARGIN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic [10:0] x_ball,
  input  logic        start,
  output logic        still_graphic,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic        goal,
  output logic [1:0]  winner,
  output game_state_t state
);
  localparam logic [10:0] L_THR   = 11'(GOAL_MARGIN);
  localparam logic [10:0] R_THR   = 11'(HOR_PIXELS - BALL_SIZE - GOAL_MARGIN);
  localparam logic [3:0]  WIN4    = 4'(WIN_SCORE);
  localparam logic [1:0]  WIN_L   = 2'b01;
  localparam logic [1:0]  WIN_R   = 2'b10;

  game_state_t r_state;
  logic [3:0]  r_score_l;
  logic [3:0]  r_score_r;
  logic        r_goal;
  logic [1:0]  r_winner;
  logic        r_start_q;

  game_state_t w_nxt_state;
  logic [3:0]  w_nxt_l;
  logic [3:0]  w_nxt_r;
  logic        w_nxt_goal;
  logic [1:0]  w_nxt_winner;
  logic        w_start_rise;
  logic        w_serve_done;
  logic        w_hit_r;
  logic        w_hit_l;
  logic [3:0]  w_sat_l;
  logic [3:0]  w_sat_r;

  assign w_start_rise = start & ~r_start_q;
  // Left-edge goal takes priority if both thresholds are ever met together.
  assign w_hit_r = (x_ball <= L_THR);
  assign w_hit_l = (x_ball >= R_THR) & ~w_hit_r;
  assign w_sat_l = (r_score_l == 4'hF) ? 4'hF : r_score_l + 4'd1;
  assign w_sat_r = (r_score_r == 4'hF) ? 4'hF : r_score_r + 4'd1;

  // Held clear outside SERVE so every serve pause starts from zero.
  tick_counter #(
    .MAX (PAUSE_TICKS)
  ) u_serve_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (r_state != SERVE),
    .en    (r_state == SERVE),
    .tick  (timing_tick),
    .done  (w_serve_done)
  );

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_l      = r_score_l;
    w_nxt_r      = r_score_r;
    w_nxt_goal   = 1'b0;
    w_nxt_winner = r_winner;
    case (r_state)
      IDLE, OVER: begin
        if (w_start_rise) begin
          w_nxt_state  = SERVE;
          w_nxt_l      = '0;
          w_nxt_r      = '0;
          w_nxt_winner = '0;
        end
      end
      SERVE: begin
        if (w_serve_done) begin
          w_nxt_state = PLAY;
        end
      end
      PLAY: begin
        if (timing_tick && w_hit_r) begin
          w_nxt_goal = 1'b1;
          w_nxt_r    = w_sat_r;
          if (w_sat_r == WIN4) begin
            w_nxt_winner = WIN_R;
            w_nxt_state  = OVER;
          end else begin
            w_nxt_state = SERVE;
          end
        end else if (timing_tick && w_hit_l) begin
          w_nxt_goal = 1'b1;
          w_nxt_l    = w_sat_l;
          if (w_sat_l == WIN4) begin
            w_nxt_winner = WIN_L;
            w_nxt_state  = OVER;
          end else begin
            w_nxt_state = SERVE;
          end
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_score_l <= '0;
      r_score_r <= '0;
      r_goal    <= 1'b0;
      r_winner  <= '0;
      r_start_q <= 1'b1;
    end else begin
      r_state   <= w_nxt_state;
      r_score_l <= w_nxt_l;
      r_score_r <= w_nxt_r;
      r_goal    <= w_nxt_goal;
      r_winner  <= w_nxt_winner;
      r_start_q <= start;
    end
  end

  assign state         = r_state;
  assign still_graphic = (r_state != PLAY);
  assign score_left    = r_score_l;
  assign score_right   = r_score_r;
  assign goal          = r_goal;
  assign winner        = r_winner;
endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm with WIN_SCORE=5, PAUSE_TICKS=3, GOAL_MARGIN=8.
module tb_game_fsm;
  import pong_pkg::*;

  logic        clk;
  logic        rst;
  logic        timing_tick;
  logic [10:0] x_ball;
  logic        start;
  logic        still_graphic;
  logic [3:0]  score_left;
  logic [3:0]  score_right;
  logic        goal;
  logic [1:0]  winner;
  game_state_t state;

  int checks;
  int failures;

  game_fsm #(
    .WIN_SCORE   (5),
    .PAUSE_TICKS (3),
    .GOAL_MARGIN (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .timing_tick   (timing_tick),
    .x_ball        (x_ball),
    .start         (start),
    .still_graphic (still_graphic),
    .score_left    (score_left),
    .score_right   (score_right),
    .goal          (goal),
    .winner        (winner),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    timing_tick = 1'b1;
    step();
    timing_tick = 1'b0;
    step();
  endtask

  task automatic serve_to_play();
    for (int i = 0; i < 3; i++) tick_once();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if (state !== IDLE || still_graphic !== 1'b1 || goal !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got state=%0d still=%b goal=%b exp state=%0d still=1 goal=0", state, still_graphic, goal, IDLE);
    end
    checks++;
    if (score_left !== 4'd0 || score_right !== 4'd0 || winner !== 2'b00) begin
      failures++;
      $display("FAIL reset_scores got %0d/%0d win=%b exp 0/0 win=00", score_left, score_right, winner);
    end
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (state !== IDLE || still_graphic !== 1'b1) begin
      failures++;
      $display("FAIL held_start got state=%0d still=%b exp state=%0d still=1", state, still_graphic, IDLE);
    end
  endtask

  task automatic test_start();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    checks++;
    if (state !== SERVE || still_graphic !== 1'b1 || score_left !== 4'd0 || score_right !== 4'd0) begin
      failures++;
      $display("FAIL start_edge got state=%0d still=%b score=%0d/%0d exp state=%0d still=1 score=0/0", state, still_graphic, score_left, score_right, SERVE);
    end
    start = 1'b0;
  endtask

  task automatic test_serve();
    tick_once();
    start = 1'b1; step(); start = 1'b0; step();
    checks++;
    if (state !== SERVE) begin
      failures++;
      $display("FAIL serve_start_ignored got state=%0d exp %0d", state, SERVE);
    end
    tick_once();
    checks++;
    if (state !== SERVE || still_graphic !== 1'b1) begin
      failures++;
      $display("FAIL serve_two_ticks got state=%0d still=%b exp state=%0d still=1", state, still_graphic, SERVE);
    end
    timing_tick = 1'b1;
    step();
    timing_tick = 1'b0;
    checks++;
    if (state !== PLAY || still_graphic !== 1'b0) begin
      failures++;
      $display("FAIL serve_third_tick got state=%0d still=%b exp state=%0d still=0", state, still_graphic, PLAY);
    end
    start = 1'b1; step(); start = 1'b0; step();
    checks++;
    if (state !== PLAY) begin
      failures++;
      $display("FAIL play_start_ignored got state=%0d exp %0d", state, PLAY);
    end
  endtask

  task automatic test_goal_right();
    x_ball = 11'd9; timing_tick = 1'b1;
    step();
    timing_tick = 1'b0;
    checks++;
    if (goal !== 1'b0 || score_right !== 4'd0 || state !== PLAY) begin
      failures++;
      $display("FAIL right_x9 got goal=%b sr=%0d state=%0d exp goal=0 sr=0 state=%0d", goal, score_right, state, PLAY);
    end
    x_ball = 11'd8; timing_tick = 1'b1;
    step();
    timing_tick = 1'b0; x_ball = 11'd500;
    checks++;
    if (goal !== 1'b1 || score_right !== 4'd1 || score_left !== 4'd0 || state !== SERVE || still_graphic !== 1'b1) begin
      failures++;
      $display("FAIL right_x8 got goal=%b sr=%0d sl=%0d state=%0d still=%b exp goal=1 sr=1 sl=0 state=%0d still=1", goal, score_right, score_left, state, still_graphic, SERVE);
    end
    step();
    checks++;
    if (goal !== 1'b0) begin
      failures++;
      $display("FAIL goal_one_cycle got goal=%b exp 0", goal);
    end
  endtask

  task automatic test_goal_left();
    serve_to_play();
    x_ball = 11'd1000; timing_tick = 1'b1;
    step();
    timing_tick = 1'b0;
    checks++;
    if (goal !== 1'b0 || score_left !== 4'd0 || state !== PLAY) begin
      failures++;
      $display("FAIL left_x1000 got goal=%b sl=%0d state=%0d exp goal=0 sl=0 state=%0d", goal, score_left, state, PLAY);
    end
    x_ball = 11'd1001;
    step();
    checks++;
    if (goal !== 1'b0 || score_left !== 4'd0 || state !== PLAY) begin
      failures++;
      $display("FAIL left_no_tick got goal=%b sl=%0d state=%0d exp goal=0 sl=0 state=%0d", goal, score_left, state, PLAY);
    end
    timing_tick = 1'b1;
    step();
    timing_tick = 1'b0; x_ball = 11'd500;
    checks++;
    if (goal !== 1'b1 || score_left !== 4'd1 || score_right !== 4'd1 || state !== SERVE) begin
      failures++;
      $display("FAIL left_x1001 got goal=%b sl=%0d sr=%0d state=%0d exp goal=1 sl=1 sr=1 state=%0d", goal, score_left, score_right, state, SERVE);
    end
  endtask

  task automatic test_match_end();
    for (int g = 2; g <= 4; g++) begin
      serve_to_play();
      x_ball = 11'd1001; timing_tick = 1'b1;
      step();
      timing_tick = 1'b0; x_ball = 11'd500;
    end
    checks++;
    if (score_left !== 4'd4 || state !== SERVE || winner !== 2'b00) begin
      failures++;
      $display("FAIL left_four got sl=%0d state=%0d win=%b exp sl=4 state=%0d win=00", score_left, state, winner, SERVE);
    end
    serve_to_play();
    x_ball = 11'd1001; timing_tick = 1'b1;
    step();
    timing_tick = 1'b0;
    checks++;
    if (winner !== 2'b01 || state !== OVER || still_graphic !== 1'b1 || score_left !== 4'd5 || goal !== 1'b1) begin
      failures++;
      $display("FAIL match_win got win=%b state=%0d still=%b sl=%0d goal=%b exp win=01 state=%0d still=1 sl=5 goal=1", winner, state, still_graphic, score_left, goal, OVER);
    end
    x_ball = 11'd1005;
    for (int i = 0; i < 3; i++) tick_once();
    checks++;
    if (score_left !== 4'd5 || score_right !== 4'd1 || state !== OVER || winner !== 2'b01 || goal !== 1'b0) begin
      failures++;
      $display("FAIL over_hold got sl=%0d sr=%0d state=%0d win=%b goal=%b exp sl=5 sr=1 state=%0d win=01 goal=0", score_left, score_right, state, winner, goal, OVER);
    end
    x_ball = 11'd500;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (state !== SERVE || score_left !== 4'd0 || score_right !== 4'd0 || winner !== 2'b00) begin
      failures++;
      $display("FAIL over_restart got state=%0d sl=%0d sr=%0d win=%b exp state=%0d 0/0 win=00", state, score_left, score_right, winner, SERVE);
    end
  endtask

  task automatic test_reset_mid();
    serve_to_play();
    x_ball = 11'd8; timing_tick = 1'b1;
    step();
    timing_tick = 1'b0; x_ball = 11'd500;
    serve_to_play();
    checks++;
    if (state !== PLAY || score_right !== 4'd1) begin
      failures++;
      $display("FAIL pre_reset got state=%0d sr=%0d exp state=%0d sr=1", state, score_right, PLAY);
    end
    x_ball = 11'd1001; timing_tick = 1'b1; rst = 1'b1;
    step();
    timing_tick = 1'b0; rst = 1'b0; x_ball = 11'd500;
    checks++;
    if (state !== IDLE || score_left !== 4'd0 || score_right !== 4'd0 || goal !== 1'b0 || still_graphic !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid got state=%0d sl=%0d sr=%0d goal=%b still=%b exp state=%0d 0/0 goal=0 still=1", state, score_left, score_right, goal, still_graphic, IDLE);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; timing_tick = 1'b0; x_ball = 11'd500; start = 1'b0;
    test_reset();
    test_start();
    test_serve();
    test_goal_right();
    test_goal_left();
    test_match_end();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/game_fsm.md
# game_fsm

Match-level controller for Pong. It watches the ball position from `ball_controller`, detects goals, and keeps both players' scores. It runs the serve pause between rallies and declares the winner. It drives `still_graphic` back into `ball_controller` and feeds score and winner data to the on-screen score renderer.

## Interface
Parameters:
- `WIN_SCORE`, 5: score that ends the match (1..15).
- `PAUSE_TICKS`, 60: `timing_tick` pulses spent in SERVE before play resumes (≥1).
- `GOAL_MARGIN`, 8: goal threshold distance from either screen edge, in pixels.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `timing_tick`, in, 1: one-cycle frame-rate pulse, the same pulse that drives `ball_controller`.
- `x_ball`, in, 11: ball left-edge x coordinate from `ball_controller`.
- `start`, in, 1: debounced start-button level.
- `still_graphic`, out, 1: freezes and recentres the ball when high.
- `score_left`, out, 4: left-player score.
- `score_right`, out, 4: right-player score.
- `goal`, out, 1: one-cycle pulse on every scored goal.
- `winner`, out, 2: 00 none, 01 left, 10 right.
- `state`, out, `game_state_t`: current state, for debug and the renderer.

## Operation
- States: IDLE, SERVE, PLAY, OVER.
- **IDLE**:
  - `still_graphic`=1.
  - A rising edge of `start` clears both scores, clears `winner` and the serve counter, and moves to SERVE.
- **SERVE**:
  - `still_graphic`=1.
  - The serve counter increments on each `timing_tick`.
  - When a tick arrives with counter = `PAUSE_TICKS`-1, the FSM moves to PLAY and clears the counter.
- **PLAY**:
  - `still_graphic`=0.
  - Goals are evaluated only on cycles where `timing_tick`=1.
  - `x_ball` ≤ `GOAL_MARGIN` is a right-player goal.
  - `x_ball` ≥ `HOR_PIXELS` − `BALL_SIZE` − `GOAL_MARGIN` (=1001) is a left-player goal.
  - Both conditions are mutually exclusive by geometry. If both are somehow true, the left-edge (right-player) goal wins.
  - On a goal:
    - Increment the scorer's score, saturating at 15.
    - Pulse `goal`.
    - If the new score = `WIN_SCORE`: set `winner` and go to OVER.
    - Otherwise go to SERVE.
  - At most one goal is counted per PLAY entry.
- **OVER**:
  - `still_graphic`=1; scores and `winner` are held.
  - A rising edge of `start` clears scores, `winner` and the counter, and goes to SERVE.
- **`start` handling**:
  - Edge detect uses a registered copy `start_q`.
  - `start_q` resets to 1, so a button held through reset does not start a match.
  - `start` edges in SERVE or PLAY are ignored.
- **Arithmetic**:
  - All comparisons are unsigned, on 11 bits.
  - The serve counter width is `$clog2(PAUSE_TICKS)`, minimum 1.

## Timing
- All outputs are registered.
- Reset values:
  - `state`=IDLE, `still_graphic`=1.
  - Scores 0, `goal`=0, `winner`=00.
  - Counter 0, `start_q`=1.
- `still_graphic` is a Moore output, equal to (`state` != PLAY), taken from the state register.
  - It changes in the cycle after the state transition edge.
  - In that cycle `ball_controller` recentres the ball.
- Goal latency:
  - Tick cycle N with the ball past the threshold leads to `goal`=1, the updated score, the new `state` and `still_graphic`=1, all visible in cycle N+1.
  - `goal` lasts exactly one cycle.
- Start latency: rising edge sampled at cycle N leads to SERVE in cycle N+1.
- Serve duration: exactly `PAUSE_TICKS` ticks. PLAY begins the cycle after the last tick.
- Reset mid-match: takes effect on the next edge and overrides every other event, including a goal on the same cycle.

## Structure
- Shared package `pong_pkg` holds:
  - `game_state_t`, an enum of IDLE/SERVE/PLAY/OVER.
  - `BALL_SIZE`=15.
  - `X_PAD_L`=30 and `X_PAD_R`=979.
  - `HOR_PIXELS` and `VER_PIXELS` (1024/768) are taken from `vga_pkg`.
- One sub-module, `tick_counter`: a parameterised tick-driven counter with a `clear` input and a `done` pulse, used for the serve pause.
- Edge detect, goal compare, score registers and the FSM stay in `game_fsm`.

## Test plan
- **Reset and start**:
  - After reset, hold `start`=1 for 10 cycles: stays IDLE, `still_graphic`=1.
  - Release, then press: SERVE in the next cycle, scores 0/0.
- **Serve pause** (`PAUSE_TICKS`=3):
  - 3 ticks in SERVE lead to PLAY in the cycle after the 3rd tick, `still_graphic`=0.
  - 2 ticks leave the FSM still in SERVE.
- **Right-player goal**:
  - In PLAY, `x_ball`=8 with `timing_tick`=1 gives `goal` pulse, `score_right`=1, SERVE.
  - `x_ball`=9 gives no goal.
- **Left-player goal**:
  - `x_ball`=1001 on a tick gives `score_left`+1.
  - `x_ball`=1000 gives no change.
  - `x_ball`=1001 without a tick gives no change.
- **Match end** (`WIN_SCORE`=5):
  - The 5th left goal gives `winner`=01, OVER, `still_graphic`=1.
  - Further ticks with `x_ball`=1005 do not change the score.
  - A `start` edge clears everything to 0/0 and enters SERVE.
- **Reset mid-match**: `rst` asserted in the same cycle as a goal tick leads to IDLE, scores 0, no `goal` pulse.
